// File: rtl/div_share_sched.sv
// div_share_sched: one radix-2 restoring divider shared by two pipes.
// Ports: per-pipe req/op/a/b, older_pipe_i, flush_i, resp_ready_i in;
//   resp_valid_o (one-hot), resp_data_o, stall_req_o, busy_o out.
// Optional: DIV_SHARE_EARLY_OUT_EN finishes |a|<|b| in one cycle.
module div_share_sched #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid_i,
  input  logic [1:0][1:0]       req_op_i,
  input  logic [1:0][WIDTH-1:0] req_a_i,
  input  logic [1:0][WIDTH-1:0] req_b_i,
  input  logic                  older_pipe_i,
  input  logic [1:0]            flush_i,
  input  logic [1:0]            resp_ready_i,
  output logic [1:0]            resp_valid_o,
  output logic [WIDTH-1:0]      resp_data_o,
  output logic [1:0]            stall_req_o,
  output logic                  busy_o
);

  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic             r_owner;
  logic             r_op_rem;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_data;
  logic             r_qneg;
  logic             r_rneg;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_qual;
  logic             w_other;
  logic             w_hs;
  logic             w_kill;
  logic             w_acc;
  logic             w_sel;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_sgn;
  logic [WIDTH-1:0] w_aabs;
  logic [WIDTH-1:0] w_babs;
  logic             w_qneg_in;
  logic             w_rneg_in;
  logic             w_dz;
  logic             w_ovf;
  logic             w_early;
  logic             w_spec;
  logic [WIDTH-1:0] w_spec_q;
  logic [WIDTH-1:0] w_spec_r;
  logic [WIDTH-1:0] w_spec_data;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_rem_n;
  logic [WIDTH-1:0] w_quo_n;
  logic [WIDTH-1:0] w_fq;
  logic [WIDTH-1:0] w_fr;
  logic [WIDTH-1:0] w_fin;
  logic             w_last;

  assign w_qual  = req_valid_i & ~flush_i;
  assign w_other = ~r_owner;
  assign w_hs    = (r_state == S_DONE)
                 & resp_ready_i[r_owner]
                 & ~flush_i[r_owner];
  assign w_kill  = (r_state != S_IDLE)
                 & flush_i[r_owner];

  // Accept from IDLE, or chain the other pipe on handshake
  always_comb begin
    w_acc = 1'b0;
    w_sel = 1'b0;
    if (r_state == S_IDLE) begin
      w_acc = |w_qual;
      w_sel = (&w_qual) ? older_pipe_i : w_qual[1];
    end else if (w_hs) begin
      w_acc = w_qual[w_other];
      w_sel = w_other;
    end
  end

  assign w_op   = req_op_i[w_sel];
  assign w_a    = req_a_i[w_sel];
  assign w_b    = req_b_i[w_sel];
  assign w_sgn  = w_op[1];
  assign w_aabs = (w_sgn & w_a[WIDTH-1]) ? -w_a : w_a;
  assign w_babs = (w_sgn & w_b[WIDTH-1]) ? -w_b : w_b;
  assign w_qneg_in = w_sgn & (w_a[WIDTH-1] ^ w_b[WIDTH-1]);
  assign w_rneg_in = w_sgn & w_a[WIDTH-1];
  assign w_dz   = (w_b == '0);
  assign w_ovf  = w_sgn & (w_a == MIN_NEG) & (&w_b);

`ifdef DIV_SHARE_EARLY_OUT_EN
  assign w_early = ~w_dz & (w_aabs < w_babs);
`else
  assign w_early = 1'b0;
`endif

  assign w_spec = w_dz | w_ovf | w_early;

  // One-cycle results bypass the iteration entirely
  always_comb begin
    w_spec_q = '1;
    w_spec_r = w_a;
    if (w_dz) begin
      w_spec_q = '1;
      w_spec_r = w_a;
    end else if (w_ovf) begin
      w_spec_q = MIN_NEG;
      w_spec_r = '0;
    end else begin
      w_spec_q = '0;
      w_spec_r = w_rneg_in ? -w_aabs : w_aabs;
    end
  end

  assign w_spec_data = w_op[0] ? w_spec_r : w_spec_q;

  // Restoring step; r_quo shifts dividend out, quotient in
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_div};
  assign w_borrow = w_diff[WIDTH];
  assign w_rem_n  = w_borrow ? w_shift[WIDTH-1:0]
                             : w_diff[WIDTH-1:0];
  assign w_quo_n  = {r_quo[WIDTH-2:0], ~w_borrow};
  assign w_fq     = r_qneg ? -w_quo_n : w_quo_n;
  assign w_fr     = r_rneg ? -w_rem_n : w_rem_n;
  assign w_fin    = r_op_rem ? w_fr : w_fq;
  assign w_last   = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n    = r_state;
    resp_valid_o = 2'b00;
    busy_o       = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        if (w_acc)
          w_state_n = w_spec ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        if (w_last) w_state_n = S_DONE;
      end
      S_DONE: begin
        // A flushed owner never sees its result
        if (!flush_i[r_owner])
          resp_valid_o[r_owner] = 1'b1;
        if (w_hs) begin
          if (w_acc)
            w_state_n = w_spec ? S_DONE : S_BUSY;
          else
            w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    if (w_kill) w_state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner  <= 1'b0;
      r_op_rem <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_data   <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_cnt    <= '0;
    end else if (w_acc) begin
      r_owner  <= w_sel;
      r_op_rem <= w_op[0];
      r_rem    <= '0;
      r_quo    <= w_aabs;
      r_div    <= w_babs;
      r_qneg   <= w_qneg_in;
      r_rneg   <= w_rneg_in;
      r_cnt    <= '0;
      if (w_spec) r_data <= w_spec_data;
    end else if (r_state == S_BUSY) begin
      r_rem <= w_rem_n;
      r_quo <= w_quo_n;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last && !w_kill) r_data <= w_fin;
    end
  end

  assign resp_data_o = r_data;
  assign stall_req_o = req_valid_i & ~flush_i
                     & ~(resp_valid_o & resp_ready_i);

endmodule

// File: tb/tb_div_share_sched.sv
// tb_div_share_sched: directed and random checks of the shared
// divider against an arithmetic reference model.
module tb_div_share_sched;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0][1:0]  req_op;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic             older;
  logic [1:0]       flush;
  logic [1:0]       ready;
  logic [1:0]       resp_valid_o;
  logic [31:0]      resp_data_o;
  logic [1:0]       stall_req_o;
  logic             busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  div_share_sched #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_op_i     (req_op),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .older_pipe_i (older),
    .flush_i      (flush),
    .resp_ready_i (ready),
    .resp_valid_o (resp_valid_o),
    .resp_data_o  (resp_data_o),
    .stall_req_o  (stall_req_o),
    .busy_o       (busy_o)
  );

  function automatic logic [31:0] ref_res(
    input logic [31:0] a, input logic [31:0] b,
    input logic [1:0] op);
    logic [31:0] q, r;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (op[1] && a == 32'h8000_0000
                 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0;
    end else if (op[1]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return op[0] ? r : q;
  endfunction

  function automatic int ref_lat(
    input logic [31:0] a, input logic [31:0] b,
    input logic [1:0] op);
    logic [31:0] aa, bb;
    aa = (op[1] && a[31]) ? -a : a;
    bb = (op[1] && b[31]) ? -b : b;
    if (b == 0) return 1;
    if (op[1] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
`ifdef DIV_SHARE_EARLY_OUT_EN
    if (aa < bb) return 1;
`endif
    if (aa == bb + 1) return 33;
    return 33;
  endfunction

  // Drive one request, wait for response, handshake it
  task automatic do_op(input int p, input logic [1:0] op,
    input logic [31:0] a, input logic [31:0] b,
    output int lat, output logic [1:0] vld,
    output logic [31:0] data, output bit stall_ok);
    @(negedge clk);
    req_valid[p] = 1'b1;
    req_op[p] = op; req_a[p] = a; req_b[p] = b;
    ready = 2'b11;
    #1;
    stall_ok = stall_req_o[p];
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      #1;
      if (resp_valid_o == 0 && !stall_req_o[p])
        stall_ok = 1'b0;
    end while (resp_valid_o == 0 && lat < 100);
    vld = resp_valid_o;
    data = resp_data_o;
    if (stall_req_o[p]) stall_ok = 1'b0;
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 0; req_op = 0; req_a = 0; req_b = 0;
    older = 0; flush = 0; ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_tests++;
    if (resp_valid_o !== 2'b00 || resp_data_o !== 32'h0 ||
        stall_req_o !== 2'b00 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: vld=%b data=%h stall=%b busy=%b",
               resp_valid_o, resp_data_o, stall_req_o, busy_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ta [8];
    logic [31:0] tb [8];
    logic [1:0]  to [8];
    int          tp [8];
    logic [31:0] te [8];
    int          tl [8];
    int lat; logic [1:0] vld; logic [31:0] d; bit sok;
    ta = '{100, 100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
           32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
    tb = '{7, 7, 2, 2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    to = '{2'b00, 2'b01, 2'b10, 2'b11,
           2'b00, 2'b01, 2'b10, 2'b11};
    tp = '{0, 0, 1, 1, 0, 1, 1, 0};
    te = '{14, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 0};
    tl = '{33, 33, 33, 33, 1, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      do_op(tp[i], to[i], ta[i], tb[i], lat, vld, d, sok);
      n_tests++;
      if (d !== te[i] || lat != tl[i] ||
          vld !== (2'b01 << tp[i]) || !sok) begin
        n_fail++;
        $display("FAIL directed[%0d]: data=%h/%h lat=%0d/%0d vld=%b stall_ok=%0d",
                 i, d, te[i], lat, tl[i], vld, sok);
      end
    end
  endtask

  task automatic test_arbitration(input int iters);
    logic [31:0] a0, b0, a1, b1;
    logic [1:0] o0, o1;
    logic [31:0] ea, eb;
    int la, lb, lat, fst;
    bit s_ok;
    for (int it = 0; it < iters; it++) begin
      if (it == 0) begin
        a0 = 100; b0 = 7; o0 = 0;
        a1 = 1000; b1 = 10; o1 = 0; older = 1'b1;
      end else begin
        a0 = $urandom; b0 = $urandom_range(1, 5000);
        a1 = $urandom; b1 = $urandom_range(1, 5000);
        o0 = 2'($urandom); o1 = 2'($urandom);
        older = 1'($urandom);
      end
      fst = older;
      ea = fst ? ref_res(a1, b1, o1) : ref_res(a0, b0, o0);
      eb = fst ? ref_res(a0, b0, o0) : ref_res(a1, b1, o1);
      la = fst ? ref_lat(a1, b1, o1) : ref_lat(a0, b0, o0);
      lb = fst ? ref_lat(a0, b0, o0) : ref_lat(a1, b1, o1);
      @(negedge clk);
      req_valid = 2'b11; ready = 2'b11;
      req_a[0] = a0; req_b[0] = b0; req_op[0] = o0;
      req_a[1] = a1; req_b[1] = b1; req_op[1] = o1;
      #1;
      s_ok = 1'b1; lat = 0;
      do begin
        @(negedge clk); lat++; #1;
        if (!stall_req_o[1-fst]) s_ok = 1'b0;
      end while (resp_valid_o == 0 && lat < 100);
      n_tests++;
      if (resp_valid_o !== (2'b01 << fst) ||
          resp_data_o !== ea || lat != la || !s_ok) begin
        n_fail++;
        $display("FAIL arb_first[%0d]: vld=%b data=%h/%h lat=%0d/%0d wait_stall=%0d",
                 it, resp_valid_o, resp_data_o, ea, lat, la, s_ok);
      end
      @(posedge clk); #1;
      req_valid[fst] = 1'b0;
      lat = 0;
      do begin
        @(negedge clk); lat++; #1;
      end while (resp_valid_o == 0 && lat < 100);
      n_tests++;
      if (resp_valid_o !== (2'b01 << (1 - fst)) ||
          resp_data_o !== eb || lat != lb) begin
        n_fail++;
        $display("FAIL arb_second[%0d]: vld=%b data=%h/%h lat=%0d/%0d",
                 it, resp_valid_o, resp_data_o, eb, lat, lb);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
    end
  endtask

  task automatic test_flush();
    bit quiet;
    int lat; logic [1:0] vld; logic [31:0] d; bit sok;
    @(negedge clk);
    req_valid[0] = 1'b1; req_op[0] = 0;
    req_a[0] = 100; req_b[0] = 7; ready = 2'b11;
    repeat (10) @(negedge clk);
    flush[0] = 1'b1;
    #1;
    n_tests++;
    if (stall_req_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall: stall=%b want 0",
               stall_req_o[0]);
    end
    @(posedge clk); #1;
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: busy=%b want 0", busy_o);
    end
    flush[0] = 1'b0; req_valid[0] = 1'b0;
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk); #1;
      if (resp_valid_o != 0 || busy_o) quiet = 1'b0;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL flush_quiet: got activity, want none");
    end
    do_op(0, 2'b00, 50, 5, lat, vld, d, sok);
    n_tests++;
    if (d !== 10 || lat != 33 || vld !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_after: data=%h/a lat=%0d/33 vld=%b",
               d, lat, vld);
    end
  endtask

  task automatic test_hold();
    int lat; logic [31:0] d0; bit st;
    logic [1:0] vld; logic [31:0] d; bit sok;
    @(negedge clk);
    req_valid[0] = 1'b1; req_op[0] = 0;
    req_a[0] = 1000; req_b[0] = 3; ready = 2'b00;
    lat = 0;
    do begin
      @(negedge clk); lat++; #1;
    end while (resp_valid_o == 0 && lat < 100);
    d0 = resp_data_o;
    n_tests++;
    if (d0 !== 333 || lat != 33) begin
      n_fail++;
      $display("FAIL hold_first: data=%h/14d lat=%0d/33",
               d0, lat);
    end
    st = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      if (resp_valid_o !== 2'b01 || resp_data_o !== d0 ||
          stall_req_o[0] !== 1'b1) st = 1'b0;
    end
    n_tests++;
    if (!st) begin
      n_fail++;
      $display("FAIL hold_stable: vld=%b data=%h want 01/%h",
               resp_valid_o, resp_data_o, d0);
    end
    ready = 2'b01;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n_tests++;
    if (busy_o !== 1'b0 || resp_valid_o !== 2'b00 ||
        resp_data_o !== d0) begin
      n_fail++;
      $display("FAIL hold_release: busy=%b vld=%b data=%h",
               busy_o, resp_valid_o, resp_data_o);
    end
    do_op(0, 2'b00, 3, 10, lat, vld, d, sok);
    n_tests++;
    if (d !== 0 || lat != ref_lat(3, 10, 2'b00)) begin
      n_fail++;
      $display("FAIL early_out: data=%h/0 lat=%0d/%0d",
               d, lat, ref_lat(3, 10, 2'b00));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid[1] = 1'b1; req_op[1] = 0;
    req_a[1] = 77; req_b[1] = 7; ready = 2'b11;
    repeat (6) @(negedge clk);
    rst = 1'b1; req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if (busy_o !== 1'b0 || resp_valid_o !== 2'b00 ||
        resp_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b vld=%b data=%h",
               busy_o, resp_valid_o, resp_data_o);
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] a, b, e;
    logic [1:0] op;
    int p, el, lat;
    logic [1:0] vld; logic [31:0] d; bit sok;
    for (int i = 0; i < n; i++) begin
      p = $urandom_range(0, 1);
      op = 2'($urandom);
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000
                                      : $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 15);
        3: b = -$urandom_range(1, 300);
        default: b = $urandom;
      endcase
      e = ref_res(a, b, op);
      el = ref_lat(a, b, op);
      do_op(p, op, a, b, lat, vld, d, sok);
      n_tests++;
      if (d !== e || lat != el || vld !== (2'b01 << p) ||
          !sok) begin
        n_fail++;
        $display("FAIL rand[%0d] p%0d op%b %h/%h: data=%h/%h lat=%0d/%0d vld=%b",
                 i, p, op, a, b, d, e, lat, el, vld);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_arbitration(6);
    test_flush();
    test_hold();
    test_reset_mid();
    test_random(25);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_share_sched.md
Name: div_share_sched

Overview:
- Scheduler for one iterative 32-bit divider shared by the two backend pipes (pipe 0 = main, pipe 1 = secondary).
- Arbitrates simultaneous EX-stage divide requests in program order using the issue revert flag.
- Sequences the radix-2 restoring iteration and returns the quotient or remainder to the owning pipe.
- Drives per-pipe EX stall requests into the backend stall controller and aborts work when the owner's instruction is cleared.

Parameters:
- WIDTH, 32, operand/result width; iteration count per divide.
- CNT_W, 6, width of the iteration counter; must hold the value WIDTH.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  2  per-pipe divide request; held until the response handshake or a flush
- req_op_i  in  2x2  per pipe: bit0 = return remainder (else quotient), bit1 = signed
- req_a_i  in  2xWIDTH  per-pipe dividend
- req_b_i  in  2xWIDTH  per-pipe divisor
- older_pipe_i  in  1  pipe holding the older instruction when both request (the revert flag)
- flush_i  in  2  per-pipe EX clear; kills that pipe's request or in-flight operation
- resp_ready_i  in  2  owner pipe can consume the result (its EX stage is not stalled by a later stage)
- resp_valid_o  out  2  result valid for pipe i, one-hot
- resp_data_o  out  WIDTH  result, shared; qualified by resp_valid_o
- stall_req_o  out  2  EX stall request per pipe
- busy_o  out  1  divider not IDLE

Behaviour:
- Outputs on reset: resp_valid_o=0, resp_data_o=0, stall_req_o=0, busy_o=0; state = IDLE; all internal registers cleared.
- stall_req_o[i] = req_valid_i[i] & ~flush_i[i] & ~(resp_valid_o[i] & resp_ready_i[i]). This is combinational.
- State IDLE:
  - Arbitration considers only requests with req_valid_i & ~flush_i.
  - If both requests qualify, pipe older_pipe_i wins. Otherwise the single qualifying pipe wins.
  - On accept, register: owner, op, |a| and |b| (absolute values only when signed), quotient sign = a[31]^b[31], remainder sign = a[31]. Counter cleared to 0.
  - Divisor == 0: go to DONE with q = all-ones, r = a, no sign fixup.
  - Signed a = 0x80000000 and b = 0xFFFFFFFF: go to DONE with q = 0x80000000, r = 0.
  - Otherwise go to BUSY.
- State BUSY:
  - One restoring step per cycle: shift the partial remainder left by one and bring in the next dividend bit; subtract the divisor if the result is non-negative; the quotient bit is the inverse of the borrow.
  - When counter reaches WIDTH-1, go to DONE.
- State DONE:
  - Apply the sign fixup: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Drive resp_data_o (quotient or remainder per op bit0) and resp_valid_o[owner]=1.
  - Hold DONE until resp_ready_i[owner]. Then go to IDLE, or accept the other pipe's pending request in the same cycle, applying the IDLE accept rules.
- Latency: accept at cycle t → resp_valid_o at t+WIDTH+1 (t+33). Special cases (divisor zero, signed overflow) respond at t+1.
- Flush:
  - flush_i[owner] in BUSY or DONE → IDLE next cycle; no response is ever issued for that operation.
  - A flush of the non-owner pipe does not affect the in-flight operation.
- A request from the same pipe that arrives while the divider is busy for the other pipe waits in IDLE arbitration; the requester stalls meanwhile.
- resp_data_o holds its last value outside DONE; only resp_valid_o qualifies it.
- Reset asserted mid-operation → IDLE in the next cycle; the result is discarded.

Optional Feature:
- Macro: DIV_SHARE_EARLY_OUT_EN.
- Defined: at accept, if |a| < |b| (divisor nonzero), go straight to DONE with q = 0 and r = |a|, then apply the normal sign fixup. Latency is t+1.
- Undefined: all nonzero-divisor, non-overflow operations take the full WIDTH iterations.

Test Plan:
- Pipe0, unsigned, a=100, b=7, op=quotient, resp_ready=1 → resp_valid_o=2'b01 exactly 33 cycles after accept, data=14. Repeat with op=remainder → data=2.
- Pipe1, signed, a=-7 (0xFFFFFFF9), b=2 → quotient 0xFFFFFFFD; remainder 0xFFFFFFFF.
- Both pipes request in the same cycle, older_pipe_i=1:
  - Pipe1 is served first; pipe0 stall_req_o stays 1 throughout.
  - Pipe0 is accepted in pipe1's handshake cycle; its result arrives 33 cycles later.
- Pipe0 accepted, flush_i[0] asserted at BUSY cycle 10 → IDLE next cycle, no resp_valid_o, busy_o=0. A new request is then accepted normally.
- Corner cases:
  - b=0, a=0x1234 → q=0xFFFFFFFF, r=0x1234 at t+1.
  - Signed a=0x80000000, b=-1 → q=0x80000000, r=0.
- Hold resp_ready_i[0]=0 for 5 cycles in DONE → data and resp_valid_o stable; with DIV_SHARE_EARLY_OUT_EN, a=3, b=10 → q=0 at t+1.
